bp_reg_initiator: RTL and testbench

//  Bytepipe register-access initiator: the host-side counterpart of the bpReg

---
 rtl/bp_reg_pkg.sv | 25 ++
 rtl/bp_reg_initiator.sv | 153 +++++++++++++++
 tb/tb_bp_reg_initiator.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_reg_pkg.sv
// Shared types and constants for the bytepipe register-access initiator.
// The command byte carries the write flag in its top bit and the register address below it.
package bp_reg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_CMD  = 3'd1,
        TX_DATA = 3'd2,
        RX_DATA = 3'd3,
        RSP     = 3'd4
    } bpState_t;

    localparam int BP_CMD_WRITE_BIT = 7;
    localparam int BP_ADDR_W        = 7;
    localparam int BP_DATA_W        = 8;

    function automatic logic [BP_DATA_W-1:0] bpCmdByte(input logic isWrite,
                                                      input logic [BP_ADDR_W-1:0] addr);
        logic [BP_DATA_W-1:0] cmd;
        cmd = {1'b0, addr};
        cmd[BP_CMD_WRITE_BIT] = isWrite;
        return cmd;
    endfunction

endpackage

// File: rtl/bp_reg_initiator.sv
// Host-side bytepipe register initiator: sends command/data bytes to the bpReg
// responder and returns one completion per request (read data or timeout).
module bp_reg_initiator
    import bp_reg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DROPCOUNT_W    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cg,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_write,
    input  logic [BP_ADDR_W-1:0]   i_req_addr,
    input  logic [BP_DATA_W-1:0]   i_req_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [BP_DATA_W-1:0]   o_rsp_rdata,
    output logic                   o_rsp_timeout,
    output logic [BP_DATA_W-1:0]   o_bp_data,
    output logic                   o_bp_valid,
    input  logic                   i_bp_ready,
    input  logic [BP_DATA_W-1:0]   i_bp_data,
    input  logic                   i_bp_valid,
    output logic                   o_bp_ready,
    output logic                   o_busy,
    output logic [DROPCOUNT_W-1:0] o_dropCount,
    output bpState_t               o_state
);

    // Handshakes: every valid/ready pair transfers on a rising edge where both
    // are high; a raised valid and its data hold until that edge. With i_cg low
    // all handshake outputs drop so nothing transfers and all state holds.

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bpState_t               state, stateNext;
    logic                   reqWrite, reqWriteNext;
    logic [BP_ADDR_W-1:0]   reqAddr, reqAddrNext;
    logic [BP_DATA_W-1:0]   reqWdata, reqWdataNext;
    logic [BP_DATA_W-1:0]   rspRdata, rspRdataNext;
    logic                   rspTimeout, rspTimeoutNext;
    logic [CNT_W-1:0]       toCnt, toCntNext;
    logic [DROPCOUNT_W-1:0] dropCount, dropCountNext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            reqWrite   <= 1'b0;
            reqAddr    <= '0;
            reqWdata   <= '0;
            rspRdata   <= '0;
            rspTimeout <= 1'b0;
            toCnt      <= '0;
            dropCount  <= '0;
        end else begin
            state      <= stateNext;
            reqWrite   <= reqWriteNext;
            reqAddr    <= reqAddrNext;
            reqWdata   <= reqWdataNext;
            rspRdata   <= rspRdataNext;
            rspTimeout <= rspTimeoutNext;
            toCnt      <= toCntNext;
            dropCount  <= dropCountNext;
        end
    end

    always_comb begin
        stateNext      = state;
        reqWriteNext   = reqWrite;
        reqAddrNext    = reqAddr;
        reqWdataNext   = reqWdata;
        rspRdataNext   = rspRdata;
        rspTimeoutNext = rspTimeout;
        toCntNext      = toCnt;
        dropCountNext  = dropCount;
        if (i_cg) begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        reqWriteNext = i_req_write;
                        reqAddrNext  = i_req_addr;
                        reqWdataNext = i_req_wdata;
                        stateNext    = TX_CMD;
                    end
                end
                TX_CMD: begin
                    if (i_bp_ready) begin
                        if (reqWrite) begin
                            stateNext = TX_DATA;
                        end else begin
                            stateNext = RX_DATA;
                            toCntNext = '0;
                        end
                    end
                end
                TX_DATA: begin
                    if (i_bp_ready) begin
                        rspRdataNext   = '0;
                        rspTimeoutNext = 1'b0;
                        stateNext      = RSP;
                    end
                end
                RX_DATA: begin
                    // A reply arriving on the terminal-count cycle still beats the timeout.
                    if (i_bp_valid) begin
                        rspRdataNext   = i_bp_data;
                        rspTimeoutNext = 1'b0;
                        stateNext      = RSP;
                    end else if (toCnt == CNT_LAST) begin
                        rspRdataNext   = '0;
                        rspTimeoutNext = 1'b1;
                        stateNext      = RSP;
                    end else begin
                        toCntNext = toCnt + 1'b1;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
            // Bytes accepted outside RX_DATA (late replies included) are strays.
            if (i_bp_valid && state != RX_DATA && state != RSP && !(&dropCount)) begin
                dropCountNext = dropCount + 1'b1;
            end
        end
    end

    always_comb begin
        o_bp_data = '0;
        case (state)
            TX_CMD:  o_bp_data = bpCmdByte(reqWrite, reqAddr);
            TX_DATA: o_bp_data = reqWdata;
            default: o_bp_data = '0;
        endcase
    end

    assign o_req_ready   = i_cg && (state == IDLE);
    assign o_bp_valid    = i_cg && (state == TX_CMD || state == TX_DATA);
    assign o_bp_ready    = i_cg && (state != RSP);
    assign o_rsp_valid   = i_cg && (state == RSP);
    assign o_rsp_rdata   = rspRdata;
    assign o_rsp_timeout = rspTimeout;
    assign o_busy        = (state != IDLE);
    assign o_dropCount   = dropCount;
    assign o_state       = state;

endmodule

// File: tb/tb_bp_reg_initiator.sv
// Self-checking bench for bp_reg_initiator: directed write/read/timeout/reset/clock-gate
// cases, a randomized backpressure run against a byte-stream model, and drop-count saturation.
module tb_bp_reg_initiator;
    import bp_reg_pkg::*;

    localparam int TO = 16;
    localparam int DW = 8;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic cg = 1'b1;
    logic reqValid = 1'b0, reqReady, reqWrite = 1'b0;
    logic [6:0] reqAddr = '0;
    logic [7:0] reqWdata = '0;
    logic rspValid, rspReady = 1'b0, rspTimeout;
    logic [7:0] rspRdata;
    logic [7:0] bpTxData;
    logic bpTxValid, bpTxReady = 1'b1;
    logic [7:0] bpRxData = '0;
    logic bpRxValid = 1'b0, bpRxReady;
    logic busy;
    logic [DW-1:0] dropCount;
    bpState_t dutState;

    always #5 clk = ~clk;

    bp_reg_initiator #(.TIMEOUT_CYCLES(TO), .DROPCOUNT_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_cg(cg),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_write(reqWrite),
        .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_rdata(rspRdata),
        .o_rsp_timeout(rspTimeout),
        .o_bp_data(bpTxData), .o_bp_valid(bpTxValid), .i_bp_ready(bpTxReady),
        .i_bp_data(bpRxData), .i_bp_valid(bpRxValid), .o_bp_ready(bpRxReady),
        .o_busy(busy), .o_dropCount(dropCount), .o_state(dutState)
    );

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueReq(input logic w, input logic [6:0] a, input logic [7:0] d);
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr  = a;
        reqWdata = d;
        tick();
        reqValid = 1'b0;
    endtask

    task automatic rspHandshake();
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
    endtask

    task automatic countToRsp(input string tag, input int expTicks);
        int n;
        n = 0;
        while (!rspValid && n < 100) begin
            tick();
            n++;
        end
        checkEq(tag, 32'(n), 32'(expTicks));
    endtask

    // Reference model for the random run: expected byte stream and completions.
    logic [7:0] expByteQ[$];
    logic [8:0] expRspQ[$];
    logic [7:0] replyQ[$];
    bit monOn = 1'b0;
    bit randDone = 1'b0;
    logic stallPrev = 1'b0;
    logic [7:0] stallData = '0;

    always @(negedge clk) begin
        if (monOn) begin
            logic [7:0] eb;
            logic [8:0] er;
            if (stallPrev) begin
                checkEq("bp_hold_valid", 32'(bpTxValid), 32'd1);
                checkEq("bp_hold_data", 32'(bpTxData), 32'(stallData));
            end
            stallPrev = bpTxValid && !bpTxReady;
            stallData = bpTxData;
            if (bpTxValid && bpTxReady) begin
                checkEq("bp_byte_expected", 32'(expByteQ.size() != 0), 32'd1);
                if (expByteQ.size() != 0) begin
                    eb = expByteQ.pop_front();
                    checkEq("bp_byte", 32'(bpTxData), 32'(eb));
                end
            end
            if (rspValid && rspReady) begin
                checkEq("rsp_expected", 32'(expRspQ.size() != 0), 32'd1);
                if (expRspQ.size() != 0) begin
                    er = expRspQ.pop_front();
                    checkEq("rsp_timeout", 32'(rspTimeout), 32'(er[8]));
                    checkEq("rsp_rdata", 32'(rspRdata), 32'(er[7:0]));
                end
            end
        end else begin
            stallPrev = 1'b0;
        end
    end

    task automatic requester(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            int k;
            logic w;
            logic [6:0] a;
            logic [7:0] d;
            logic [7:0] r;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat (gap) tick();
            w = 1'($urandom_range(0, 1));
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom);
            expByteQ.push_back({w, a});
            if (w) begin
                expByteQ.push_back(d);
                expRspQ.push_back(9'h000);
            end else begin
                r = 8'($urandom);
                replyQ.push_back(r);
                expRspQ.push_back({1'b0, r});
            end
            reqValid = 1'b1;
            reqWrite = w;
            reqAddr  = a;
            reqWdata = d;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!reqReady && k < 500);
            checkEq("req_accepted", 32'(reqReady), 32'd1);
            tick();
            reqValid = 1'b0;
        end
        begin
            int k;
            k = 0;
            while (expRspQ.size() != 0 && k < 2000) begin
                tick();
                k++;
            end
            checkEq("rsp_drain", 32'(expRspQ.size()), 32'd0);
            checkEq("byte_drain", 32'(expByteQ.size()), 32'd0);
        end
        randDone = 1'b1;
    endtask

    // Responder model: parses the command stream and answers each read after a random delay.
    task automatic responder();
        bit expectData;
        logic [7:0] r;
        int d;
        int k;
        expectData = 1'b0;
        while (!randDone) begin
            @(negedge clk);
            if (bpTxValid && bpTxReady) begin
                if (expectData) begin
                    expectData = 1'b0;
                end else if (bpTxData[BP_CMD_WRITE_BIT]) begin
                    expectData = 1'b1;
                end else begin
                    r = (replyQ.size() != 0) ? replyQ.pop_front() : 8'h00;
                    d = int'($urandom_range(0, 5));
                    @(posedge clk);
                    repeat (d) @(posedge clk);
                    #1;
                    bpRxValid = 1'b1;
                    bpRxData  = r;
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (!bpRxReady && k < 100);
                    checkEq("reply_accepted", 32'(bpRxReady), 32'd1);
                    tick();
                    bpRxValid = 1'b0;
                end
            end
        end
    endtask

    task automatic backpressure();
        while (!randDone) begin
            tick();
            bpTxReady = ($urandom_range(0, 3) != 0);
            rspReady  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int expDrop;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        tick();
        checkEq("rst_state", 32'(dutState), 32'(IDLE));
        checkEq("rst_req_ready", 32'(reqReady), 32'd1);
        checkEq("rst_bp_valid", 32'(bpTxValid), 32'd0);
        checkEq("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkEq("rst_rdata", 32'(rspRdata), 32'd0);
        checkEq("rst_timeout", 32'(rspTimeout), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        checkEq("rst_drop", 32'(dropCount), 32'd0);
        checkEq("rst_bp_ready", 32'(bpRxReady), 32'd1);

        // Write 0x05 <= 0xA3: bytes 0x85, 0xA3, completion on the 4th cycle
        issueReq(1'b1, 7'h05, 8'hA3);
        checkEq("wr_cmd_valid", 32'(bpTxValid), 32'd1);
        checkEq("wr_cmd_byte", 32'(bpTxData), 32'h85);
        checkEq("wr_busy", 32'(busy), 32'd1);
        tick();
        checkEq("wr_data_valid", 32'(bpTxValid), 32'd1);
        checkEq("wr_data_byte", 32'(bpTxData), 32'hA3);
        tick();
        checkEq("wr_rsp_valid", 32'(rspValid), 32'd1);
        checkEq("wr_rsp_rdata", 32'(rspRdata), 32'd0);
        checkEq("wr_rsp_timeout", 32'(rspTimeout), 32'd0);
        checkEq("wr_rsp_bp_ready", 32'(bpRxReady), 32'd0);
        rspHandshake();
        checkEq("wr_done_rsp", 32'(rspValid), 32'd0);
        checkEq("wr_done_busy", 32'(busy), 32'd0);

        // Read 0x12, reply 0x5C three cycles later
        issueReq(1'b0, 7'h12, 8'h00);
        checkEq("rd_cmd_byte", 32'(bpTxData), 32'h12);
        tick();
        checkEq("rd_rx_bp_valid", 32'(bpTxValid), 32'd0);
        checkEq("rd_rx_busy", 32'(busy), 32'd1);
        tick();
        tick();
        bpRxValid = 1'b1;
        bpRxData  = 8'h5C;
        tick();
        bpRxValid = 1'b0;
        checkEq("rd_rsp_valid", 32'(rspValid), 32'd1);
        checkEq("rd_rsp_rdata", 32'(rspRdata), 32'h5C);
        checkEq("rd_rsp_timeout", 32'(rspTimeout), 32'd0);
        rspHandshake();

        // Read with no reply: timeout after TO receive cycles, late byte is a stray
        issueReq(1'b0, 7'h33, 8'h00);
        tick();
        countToRsp("to_rx_cycles", TO);
        checkEq("to_flag", 32'(rspTimeout), 32'd1);
        checkEq("to_rdata", 32'(rspRdata), 32'd0);
        rspHandshake();
        bpRxValid = 1'b1;
        bpRxData  = 8'hE7;
        tick();
        bpRxValid = 1'b0;
        checkEq("late_drop", 32'(dropCount), 32'd1);
        checkEq("late_busy", 32'(busy), 32'd0);
        checkEq("late_req_ready", 32'(reqReady), 32'd1);

        // Reply on the terminal-count cycle wins over the timeout
        issueReq(1'b0, 7'h44, 8'h00);
        tick();
        repeat (TO - 1) tick();
        checkEq("tc_not_yet", 32'(rspValid), 32'd0);
        bpRxValid = 1'b1;
        bpRxData  = 8'h3C;
        tick();
        bpRxValid = 1'b0;
        checkEq("tc_rsp_valid", 32'(rspValid), 32'd1);
        checkEq("tc_timeout", 32'(rspTimeout), 32'd0);
        checkEq("tc_rdata", 32'(rspRdata), 32'h3C);
        rspHandshake();

        // Randomized traffic with backpressure on both sides
        monOn = 1'b1;
        fork
            requester(1000);
            responder();
            backpressure();
        join
        monOn = 1'b0;
        bpTxReady = 1'b1;
        rspReady  = 1'b0;
        tick();
        checkEq("rand_drop", 32'(dropCount), 32'd1);
        checkEq("rand_idle", 32'(busy), 32'd0);

        // Reset while holding the write data byte
        bpTxReady = 1'b0;
        issueReq(1'b1, 7'h2A, 8'h6D);
        bpTxReady = 1'b1;
        tick();
        bpTxReady = 1'b0;
        checkEq("rstmid_data", 32'(bpTxData), 32'h6D);
        rstN = 1'b0;
        #1;
        checkEq("rstmid_bp_valid", 32'(bpTxValid), 32'd0);
        checkEq("rstmid_busy", 32'(busy), 32'd0);
        checkEq("rstmid_drop", 32'(dropCount), 32'd0);
        tick();
        rstN = 1'b1;
        bpTxReady = 1'b1;
        tick();
        checkEq("rstmid_no_rsp", 32'(rspValid), 32'd0);
        checkEq("rstmid_req_ready", 32'(reqReady), 32'd1);

        // Clock gate low for 5 cycles mid-read: nothing transfers, counter holds
        issueReq(1'b0, 7'h51, 8'h00);
        tick();
        repeat (3) tick();
        cg = 1'b0;
        bpRxValid = 1'b1;
        bpRxData  = 8'h99;
        reqValid  = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkEq("cg_bp_ready", 32'(bpRxReady), 32'd0);
            checkEq("cg_req_ready", 32'(reqReady), 32'd0);
            checkEq("cg_rsp_valid", 32'(rspValid), 32'd0);
            tick();
        end
        cg = 1'b1;
        bpRxValid = 1'b0;
        reqValid  = 1'b0;
        #1;
        countToRsp("cg_frozen_count", TO - 3);
        checkEq("cg_timeout", 32'(rspTimeout), 32'd1);
        checkEq("cg_drop", 32'(dropCount), 32'd0);
        rspHandshake();

        // 300 stray bytes in IDLE saturate the drop counter
        expDrop = 0;
        bpRxValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bpRxData = 8'($urandom);
            tick();
            expDrop = (expDrop < DROP_MAX) ? expDrop + 1 : DROP_MAX;
            if (i == 99) checkEq("drop_100", 32'(dropCount), 32'(expDrop));
        end
        bpRxValid = 1'b0;
        checkEq("drop_sat", 32'(dropCount), 32'(expDrop));
        checkEq("drop_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
